// File: rtl/ysyx_210544_axi_arbiter.sv
// Two-port arbiter in front of the AXI bridge user port: port 0 = fetch, port 1 = data.
// Fixed priority to port 1 by default; define YSYX_210544_ARB_RR_EN for round-robin on contention.
module ysyx_210544_axi_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_valid_i,
  input  logic              m0_op_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [2:0]        m0_size_i,
  input  logic [7:0]        m0_blks_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ready_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_resp_o,

  input  logic              m1_valid_i,
  input  logic              m1_op_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [2:0]        m1_size_i,
  input  logic [7:0]        m1_blks_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ready_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_resp_o,

  output logic              s_valid_o,
  output logic              s_op_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [2:0]        s_size_o,
  output logic [7:0]        s_blks_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_resp_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_s_valid;
  logic                r_s_op;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [2:0]          r_s_size;
  logic [7:0]          r_s_blks;
  logic [DATA_W-1:0]   r_s_wdata;

  logic                w_any_req;
  logic                w_winner;
  logic                w_grant;
  logic                w_done;
  logic                w_sel_op;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [2:0]          w_sel_size;
  logic [7:0]          w_sel_blks;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_any_req = m0_valid_i | m1_valid_i;

`ifdef YSYX_210544_ARB_RR_EN
  // On a tie the port that did not win last time goes next.
  assign w_winner = (m0_valid_i & m1_valid_i) ? ~r_last_owner : m1_valid_i;
`else
  assign w_winner = m1_valid_i;
`endif

  assign w_sel_op    = w_winner ? m1_op_i    : m0_op_i;
  assign w_sel_addr  = w_winner ? m1_addr_i  : m0_addr_i;
  assign w_sel_size  = w_winner ? m1_size_i  : m0_size_i;
  assign w_sel_blks  = w_winner ? m1_blks_i  : m0_blks_i;
  assign w_sel_wdata = w_winner ? m1_wdata_i : m0_wdata_i;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ready_i) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_s_valid    <= 1'b0;
      r_s_op       <= 1'b0;
      r_s_addr     <= '0;
      r_s_size     <= '0;
      r_s_blks     <= '0;
      r_s_wdata    <= '0;
    end else if (w_grant) begin
      r_owner   <= w_winner;
      r_s_valid <= 1'b1;
      r_s_op    <= w_sel_op;
      r_s_addr  <= w_sel_addr;
      r_s_size  <= w_sel_size;
      r_s_blks  <= w_sel_blks;
      r_s_wdata <= w_sel_wdata;
    end else if (w_done) begin
      r_s_valid    <= 1'b0;
      r_last_owner <= r_owner;
    end
  end

  assign s_valid_o = r_s_valid;
  assign s_op_o    = r_s_op;
  assign s_addr_o  = r_s_addr;
  assign s_size_o  = r_s_size;
  assign s_blks_o  = r_s_blks;
  assign s_wdata_o = r_s_wdata;

  // Completion goes only to the owner; read data/resp are broadcast and qualified by ready.
  assign m0_ready_o = w_done & ~r_owner;
  assign m1_ready_o = w_done &  r_owner;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign m0_resp_o  = s_resp_i;
  assign m1_resp_o  = s_resp_i;

  a_last_owner_tracks : assert property (@(posedge clock) disable iff (reset)
    (r_state == ST_DONE) |-> (r_last_owner == r_owner));

endmodule
